ag32gbd_frame_bram_ctrl: RTL
============================

# ag32gbd_frame_bram_ctrl

Parametrised frame/register memory controller for the camera capture path. It fronts one true-dual-port block RAM that holds a register window plus `NUM_BUFS` rotating image buffers. Port A is arbitrated among register writes, register reads and capture-side buffer writes, with anti-starvation for the capture writer. Port B is dedicated to display-side buffer reads. It replaces the fixed two-buffer, edge-triggered controller with valid/ready handshakes, pipelined reads and N-way buffer rotation.

## Interface
Parameters:
- `DATA_W`, 8, data width of every port.
- `BUF_DEPTH`, 256, words per image buffer; must be a power of two.
- `NUM_BUFS`, 2, number of image buffers, 2..4.
- `REG_DEPTH`, 256, words in the register window; must be a power of two.
- `STARVE_LIMIT`, 15, consecutive cycles a stalled buffer write may lose arbitration before it is force-granted; 0 disables forcing.

Ports:
- `sys_clock` in 1: clock.
- `resetn` in 1: reset, synchronous, active-low.
- `flip_i` in 1: single-cycle pulse that rotates the buffers.
- `rw_valid`, `rw_addr[clog2(REG_DEPTH)]`, `rw_data[DATA_W]` in; `rw_ready` out: register write.
- `rr_valid`, `rr_addr[clog2(REG_DEPTH)]` in; `rr_ready` out: register read request.
- `rr_rvalid` out 1, `rr_rdata` out DATA_W: register read response.
- `bw_valid`, `bw_offset[clog2(BUF_DEPTH)]`, `bw_data[DATA_W]` in; `bw_ready` out: back-buffer write.
- `br_valid`, `br_offset[clog2(BUF_DEPTH)]` in; `br_ready` out: front-buffer read request.
- `br_rvalid` out 1, `br_rdata` out DATA_W: front-buffer read response.
- `back_idx_o` out clog2(NUM_BUFS): buffer currently written.
- `front_idx_o` out clog2(NUM_BUFS): buffer currently read.

## Operation
- Memory map: buffer k occupies `k*BUF_DEPTH .. k*BUF_DEPTH+BUF_DEPTH-1`. The register window starts at `NUM_BUFS*BUF_DEPTH`. RAM address width is `clog2(NUM_BUFS*BUF_DEPTH+REG_DEPTH)`. Offsets are zero-extended and added to the base, so no wrap into a neighbouring region is possible.
- Port A arbitration is combinational each cycle. Fixed priority is rw > rr > bw. Exactly one `*_ready` is high, only for a requester whose valid is high. A transfer occurs when valid & ready are high at a clock edge.
- Starvation: `starve_cnt` increments each cycle `bw_valid` is high and not granted, and clears when bw is granted or `bw_valid` is low. When `starve_cnt == STARVE_LIMIT`, bw takes the top priority for that cycle.
- Port B: `br_ready = 1` always. Every cycle accepts one read.
- Rotation: on `flip_i`, `front_idx <= back_idx` and `back_idx <= (back_idx+1) mod NUM_BUFS`. With 2 buffers this is a swap; with 3 or more, the display lags one frame behind capture.
- Requests accepted in the same cycle as `flip_i` use the pre-flip indices. In-flight reads complete from their latched address.
- Reads are fully pipelined and in order per port. A 2-stage valid shift register per port tags the response. Back-to-back reads return back-to-back.

## Timing
- Reset values: `back_idx=0`, `front_idx=NUM_BUFS-1`, `starve_cnt=0`, both rvalid pipelines cleared, `rr_rvalid=0`, `br_rvalid=0`, `rr_rdata=0`, `br_rdata=0`, RAM enables 0.
- Reset asserted mid-read squashes pending responses; no rvalid appears after reset.
- Handshake: `*_ready` may depend combinationally on valids. Valid must hold with stable payload until it is accepted.
- Write accepted at edge N: RAM enable and address are registered at edge N, and the RAM is written at edge N+1.
- Read accepted at edge N: address is registered at N, RAM q is valid after N+1, and `*_rdata`/`*_rvalid` are registered at N+2. rvalid is a one-cycle pulse per accepted read.
- Read-during-write on port A to the same address: the response returns old data (RAM old-data mode). Port B reads of the back buffer are impossible by construction, except across a flip boundary, where old data is acceptable.

## Structure
- Package `ag32gbd_mem_pkg`: `clog2` function, region base-address function, arbitration-grant enum (`GNT_NONE`, `GNT_RW`, `GNT_RR`, `GNT_BW`).
- One sub-module, `ag32gbd_tdp_bram`: behavioural true-dual-port RAM with 1-cycle registered output and per-port rden/wren, mapped to the vendor macro.
- Arbiter, rotation logic and response pipelines stay in the top level.

## Test plan
- Reset, then `bw` write offset 0x05 = 0xA5, then `flip_i`, then `br` read offset 0x05 → `br_rdata=0xA5` with `br_rvalid` exactly 2 cycles after acceptance.
- rw, rr and bw valid simultaneously with `STARVE_LIMIT=3` → grant order rw, rw…; bw is force-granted on the 4th stalled cycle, and `starve_cnt` returns to 0.
- `NUM_BUFS=3`: three flips → `back_idx` goes 1, 2, 0 and `front_idx` goes 0, 1, 2.
- Four back-to-back `rr` reads of addresses 0..3 preloaded with 0x10..0x13 → four consecutive rvalid cycles carrying 0x10..0x13 in order.
- `flip_i` in the same cycle as a bw write to offset 0x20 → the data lands in the pre-flip back buffer, and a read of offset 0x20 after the flip returns it.
- `resetn` low one cycle after a br read is accepted → no `br_rvalid`, and both indices return to their reset values.

Source files
------------

// File: rtl/ag32gbd_mem_pkg.sv
// Shared types and helpers for the frame/register BRAM controller.
// Covers width calculation, region base addresses and port-A grant encoding.
package ag32gbd_mem_pkg;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_RW,
    GNT_RR,
    GNT_BW
  } grant_t;

  // Minimum of 1 so that single-entry ranges still get a usable bus.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned w;
    for (w = 1; (32'd1 << w) < value; w++) begin
    end
    return w;
  endfunction

  function automatic int unsigned regionBase(input int unsigned idx, input int unsigned depth);
    return idx * depth;
  endfunction

endpackage

// File: rtl/ag32gbd_tdp_bram.sv
// Behavioural true-dual-port block RAM, 1-cycle registered read, old-data on collision.
// Port B is written last in the cycle if both ports write the same word.
module ag32gbd_tdp_bram #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              sys_clock,
  input  logic              aRden,
  input  logic              aWren,
  input  logic [ADDR_W-1:0] aAddr,
  input  logic [DATA_W-1:0] aWdata,
  output logic [DATA_W-1:0] aQ,
  input  logic              bRden,
  input  logic              bWren,
  input  logic [ADDR_W-1:0] bAddr,
  input  logic [DATA_W-1:0] bWdata,
  output logic [DATA_W-1:0] bQ
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge sys_clock) begin
    if (aWren) mem[aAddr] <= aWdata;
    if (bWren) mem[bAddr] <= bWdata;
    if (aRden) aQ <= mem[aAddr];
    if (bRden) bQ <= mem[bAddr];
  end

endmodule

// File: rtl/ag32gbd_frame_bram_ctrl.sv
// Frame/register memory controller: port A arbitrates register and capture traffic,
// port B serves display reads from the front buffer; NUM_BUFS buffers rotate on flip_i.
module ag32gbd_frame_bram_ctrl
  import ag32gbd_mem_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned BUF_DEPTH    = 256,
  parameter int unsigned NUM_BUFS     = 2,
  parameter int unsigned REG_DEPTH    = 256,
  parameter int unsigned STARVE_LIMIT = 15
) (
  input  logic                           sys_clock,
  input  logic                           resetn,
  input  logic                           flip_i,
  input  logic                           rw_valid,
  input  logic [clog2(REG_DEPTH)-1:0]    rw_addr,
  input  logic [DATA_W-1:0]              rw_data,
  output logic                           rw_ready,
  input  logic                           rr_valid,
  input  logic [clog2(REG_DEPTH)-1:0]    rr_addr,
  output logic                           rr_ready,
  output logic                           rr_rvalid,
  output logic [DATA_W-1:0]              rr_rdata,
  input  logic                           bw_valid,
  input  logic [clog2(BUF_DEPTH)-1:0]    bw_offset,
  input  logic [DATA_W-1:0]              bw_data,
  output logic                           bw_ready,
  input  logic                           br_valid,
  input  logic [clog2(BUF_DEPTH)-1:0]    br_offset,
  output logic                           br_ready,
  output logic                           br_rvalid,
  output logic [DATA_W-1:0]              br_rdata,
  output logic [clog2(NUM_BUFS)-1:0]     back_idx_o,
  output logic [clog2(NUM_BUFS)-1:0]     front_idx_o
);

  localparam int unsigned IDX_W     = clog2(NUM_BUFS);
  localparam int unsigned ADDR_W    = clog2(NUM_BUFS * BUF_DEPTH + REG_DEPTH);
  localparam int unsigned CNT_W     = clog2(STARVE_LIMIT + 1);
  localparam int unsigned REG_BASE  = regionBase(NUM_BUFS, BUF_DEPTH);
  localparam bit          STARVE_EN = (STARVE_LIMIT != 0);

  grant_t            grant;
  logic              forceBw;
  logic [CNT_W-1:0]  starveCnt;
  logic [IDX_W-1:0]  backIdx;
  logic [IDX_W-1:0]  frontIdx;

  logic [ADDR_W-1:0] rwAddr;
  logic [ADDR_W-1:0] rrAddr;
  logic [ADDR_W-1:0] bwAddr;
  logic [ADDR_W-1:0] brAddr;
  logic [ADDR_W-1:0] aAddrNext;
  logic [DATA_W-1:0] aDataNext;

  logic              aEn;
  logic              aWe;
  logic [ADDR_W-1:0] aAddr;
  logic [DATA_W-1:0] aWdata;
  logic              bEn;
  logic [ADDR_W-1:0] bAddr;
  logic [DATA_W-1:0] aQ;
  logic [DATA_W-1:0] bQ;
  logic [1:0]        rrPipe;
  logic [1:0]        brPipe;

  assign rwAddr = ADDR_W'(REG_BASE) + ADDR_W'(rw_addr);
  assign rrAddr = ADDR_W'(REG_BASE) + ADDR_W'(rr_addr);
  assign bwAddr = ADDR_W'(regionBase(32'(backIdx), BUF_DEPTH)) + ADDR_W'(bw_offset);
  assign brAddr = ADDR_W'(regionBase(32'(frontIdx), BUF_DEPTH)) + ADDR_W'(br_offset);

  // A capture write that has lost STARVE_LIMIT times in a row jumps the queue once.
  assign forceBw = STARVE_EN && bw_valid && (starveCnt == CNT_W'(STARVE_LIMIT));

  always_comb begin
    grant = GNT_NONE;
    if (forceBw)       grant = GNT_BW;
    else if (rw_valid) grant = GNT_RW;
    else if (rr_valid) grant = GNT_RR;
    else if (bw_valid) grant = GNT_BW;
  end

  assign rw_ready = (grant == GNT_RW);
  assign rr_ready = (grant == GNT_RR);
  assign bw_ready = (grant == GNT_BW);
  assign br_ready = 1'b1;

  always_comb begin
    aAddrNext = '0;
    aDataNext = '0;
    unique case (grant)
      GNT_RW: begin
        aAddrNext = rwAddr;
        aDataNext = rw_data;
      end
      GNT_RR: aAddrNext = rrAddr;
      GNT_BW: begin
        aAddrNext = bwAddr;
        aDataNext = bw_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clock) begin
    if (!resetn) begin
      starveCnt <= '0;
    end else if (!bw_valid || bw_ready) begin
      starveCnt <= '0;
    end else if (STARVE_EN) begin
      starveCnt <= starveCnt + 1'b1;
    end
  end

  always_ff @(posedge sys_clock) begin
    if (!resetn) begin
      backIdx  <= '0;
      frontIdx <= IDX_W'(NUM_BUFS - 1);
    end else if (flip_i) begin
      frontIdx <= backIdx;
      backIdx  <= (backIdx == IDX_W'(NUM_BUFS - 1)) ? '0 : backIdx + 1'b1;
    end
  end

  assign back_idx_o  = backIdx;
  assign front_idx_o = frontIdx;

  always_ff @(posedge sys_clock) begin
    if (!resetn) begin
      aEn    <= 1'b0;
      aWe    <= 1'b0;
      aAddr  <= '0;
      aWdata <= '0;
      bEn    <= 1'b0;
      bAddr  <= '0;
    end else begin
      aEn    <= (grant != GNT_NONE);
      aWe    <= (grant == GNT_RW) || (grant == GNT_BW);
      aAddr  <= aAddrNext;
      aWdata <= aDataNext;
      bEn    <= br_valid;
      bAddr  <= brAddr;
    end
  end

  ag32gbd_tdp_bram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) uBram (
    .sys_clock (sys_clock),
    .aRden     (aEn && !aWe),
    .aWren     (aEn && aWe),
    .aAddr     (aAddr),
    .aWdata    (aWdata),
    .aQ        (aQ),
    .bRden     (bEn),
    .bWren     (1'b0),
    .bAddr     (bAddr),
    .bWdata    ('0),
    .bQ        (bQ)
  );

  // Stage 0 tracks the registered address, stage 1 the RAM output; rdata only moves on a tagged response.
  always_ff @(posedge sys_clock) begin
    if (!resetn) begin
      rrPipe    <= '0;
      brPipe    <= '0;
      rr_rvalid <= 1'b0;
      br_rvalid <= 1'b0;
      rr_rdata  <= '0;
      br_rdata  <= '0;
    end else begin
      rrPipe    <= {rrPipe[0], rr_ready};
      brPipe    <= {brPipe[0], br_valid};
      rr_rvalid <= rrPipe[1];
      br_rvalid <= brPipe[1];
      if (rrPipe[1]) rr_rdata <= aQ;
      if (brPipe[1]) br_rdata <= bQ;
    end
  end

endmodule
